// File: rtl/vedic_mul8_seq.sv
// Sequential 8x8 unsigned Vedic multiplier: one 4x4 crosswise partial product per cycle,
// accumulated through two chained 8-bit ripple additions (low byte, then high byte).
module vedic_mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i1,
  input  logic [7:0]  i2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] Product,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state_q;
  logic [1:0]  step_q;
  logic [15:0] acc_q;
  logic [15:0] product_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;

  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  pp;
  logic [15:0] addend;
  logic [8:0]  lo_sum;
  logic [8:0]  hi_sum;
  logic [15:0] sum;
  logic        carry_hi;

  // step[0] picks the high nibble of A, step[1] the high nibble of B.
  assign mul_a = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign mul_b = step_q[1] ? b_q[7:4] : b_q[3:0];
  assign pp    = {4'h0, mul_a} * {4'h0, mul_b};

  always_comb begin
    addend = '0;
    unique case (step_q)
      2'd0:    addend = {8'h00, pp};
      2'd1:    addend = {4'h0, pp, 4'h0};
      2'd2:    addend = {4'h0, pp, 4'h0};
      2'd3:    addend = {pp, 8'h00};
      default: addend = '0;
    endcase
  end

  always_comb begin
    lo_sum   = {1'b0, acc_q[7:0]} + {1'b0, addend[7:0]};
    hi_sum   = {1'b0, acc_q[15:8]} + {1'b0, addend[15:8]} + {8'h00, lo_sum[8]};
    sum      = {hi_sum[7:0], lo_sum[7:0]};
    carry_hi = hi_sum[8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      step_q    <= 2'd0;
      acc_q     <= '0;
      product_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= i1;
            b_q     <= i2;
            acc_q   <= '0;
            step_q  <= 2'd0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          acc_q  <= sum;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            product_q <= sum;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Product   = product_q;

  // 255*255 fits in 16 bits, so the high-byte adder can never carry out.
  a_no_carry15: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == StCalc) && carry_hi));

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// Directed self-checking bench for vedic_mul8_seq.
module tb_vedic_mul8_seq;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i1;
  logic [7:0]  i2;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] product;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vedic_mul8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i1        (i1),
    .i2        (i2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [7:0] a, input logic [7:0] b, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
    end
    i1 = a;
    i2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
    i1 = ~a;
    i2 = ~b;
  endtask

  // Returns the number of edges after accept until out_valid is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL done_timeout out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++;
    if (product !== 16'h0000) begin bad++; $display("FAIL rst_product got=%h exp=0000", product); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_idle got=%0b exp=1", in_ready); end
  endtask

  task automatic test_full_scale;
    int t0;
    int edges;
    out_ready = 1'b1;
    accept(8'hFF, 8'hFF, t0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      total++;
      if (dut.carry_hi !== 1'b0) begin
        bad++;
        $display("FAIL full_carry15 got=%0b exp=0", dut.carry_hi);
      end
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    total++;
    if (edges != 4) begin bad++; $display("FAIL full_latency got=%0d exp=4", edges); end
    total++;
    if (product !== 16'hFE01) begin bad++; $display("FAIL full_product got=%h exp=fe01", product); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL full_pulse got=%0b exp=0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL full_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int t0;
    int t1;
    int edges;
    out_ready = 1'b1;
    accept(8'h12, 8'h34, t0);
    wait_done(edges);
    total++;
    if (edges != 4) begin bad++; $display("FAIL b2b_latency got=%0d exp=4", edges); end
    total++;
    if (product !== 16'h03A8) begin bad++; $display("FAIL b2b_first got=%h exp=03a8", product); end
    accept(8'hF0, 8'h0F, t1);
    total++;
    if (t1 - t0 != 6) begin bad++; $display("FAIL b2b_spacing got=%0d exp=6", t1 - t0); end
    wait_done(edges);
    total++;
    if (product !== 16'h0E10) begin bad++; $display("FAIL b2b_second got=%h exp=0e10", product); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_zero;
    int t0;
    int edges;
    out_ready = 1'b1;
    accept(8'h00, 8'hA5, t0);
    wait_done(edges);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%0b exp=1", out_valid); end
    total++;
    if (product !== 16'h0000) begin bad++; $display("FAIL zero_product got=%h exp=0000", product); end
    accept(8'h01, 8'hA5, t0);
    wait_done(edges);
    total++;
    if (product !== 16'h00A5) begin bad++; $display("FAIL one_product got=%h exp=00a5", product); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int t0;
    int edges;
    out_ready = 1'b0;
    accept(8'h0F, 8'h11, t0);
    wait_done(edges);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%0b exp=1", k, out_valid); end
      total++;
      if (product !== 16'h00FF) begin bad++; $display("FAIL bp_product[%0d] got=%h exp=00ff", k, product); end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0b exp=0", k, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%0b exp=0", out_valid); end
    total++;
    if (product !== 16'h00FF) begin bad++; $display("FAIL bp_hold got=%h exp=00ff", product); end
  endtask

  task automatic test_busy_ignored;
    int t0;
    int edges;
    out_ready = 1'b1;
    accept(8'h10, 8'h10, t0);
    i1 = 8'hFF;
    i2 = 8'hFF;
    in_valid = 1'b1;
    wait_done(edges);
    in_valid = 1'b0;
    total++;
    if (product !== 16'h0100) begin bad++; $display("FAIL busy_product got=%h exp=0100", product); end
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL busy_idle got=%0b exp=1", in_ready); end
    total++;
    if (product !== 16'h0100) begin bad++; $display("FAIL busy_hold got=%h exp=0100", product); end
  endtask

  task automatic test_reset_mid;
    int t0;
    int edges;
    out_ready = 1'b1;
    accept(8'hAB, 8'hCD, t0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%0b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
    total++;
    if (product !== 16'h0000) begin bad++; $display("FAIL mid_product got=%h exp=0000", product); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_pulse[%0d] got=%0b exp=0", k, out_valid); end
    end
    accept(8'h03, 8'h05, t0);
    wait_done(edges);
    total++;
    if (product !== 16'h000F) begin bad++; $display("FAIL mid_after got=%h exp=000f", product); end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    i1        = 8'h00;
    i2        = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset;
    test_full_scale;
    test_back_to_back;
    test_zero;
    test_backpressure;
    test_busy_ignored;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
